// File: rtl/axil_cfg_regfile_pkg.sv
// Shared constants for the batch-accelerator AXI4-Lite register file:
// register word offsets, bit positions, response codes and FSM encoding.
package axil_cfg_regfile_pkg;

  // Word offsets (byte address >> 2)
  localparam int OFF_CTRL     = 0;
  localparam int OFF_STATUS   = 1;
  localparam int OFF_CFG_BASE = 2;

  // CTRL bit positions
  localparam int CTRL_MATW  = 0;
  localparam int CTRL_RUN   = 1;
  localparam int CTRL_LAST  = 2;
  localparam int CTRL_START = 8;
  localparam int CTRL_IRQEN = 9;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_SERR = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_ADDR,   // AW accepted, waiting for W
    ST_W_DATA,   // W accepted, waiting for AW
    ST_W_RESP,
    ST_R_RESP
  } state_t;

  // Expand WSTRB into a per-bit write mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axil_cfg_regfile_fsm.sv
// AXI4-Lite handshake engine: accepts AW/W in any order, serialises writes
// ahead of reads, and presents a single-cycle commit/capture to the regfile.
module axil_lite_fsm
  import axil_cfg_regfile_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              wr_commit,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_capture,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  state_t            state;
  logic [ADDR_W-1:0] aw_q;
  logic [31:0]       w_q;
  logic [3:0]        strb_q;
  logic              aw_hs, w_hs, ar_hs;

  // Readies decode from state; AR is held off whenever a write is offered in IDLE
  always_comb begin
    S_AXI_AWREADY = ~reset & (state == ST_IDLE || state == ST_W_DATA);
    S_AXI_WREADY  = ~reset & (state == ST_IDLE || state == ST_W_ADDR);
    S_AXI_ARREADY = ~reset & (state == ST_IDLE) & ~S_AXI_AWVALID & ~S_AXI_WVALID;
    aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    wr_commit = (state == ST_IDLE   && aw_hs && w_hs) ||
                (state == ST_W_ADDR && w_hs) ||
                (state == ST_W_DATA && aw_hs);
    wr_addr    = (state == ST_W_ADDR) ? aw_q   : S_AXI_AWADDR;
    wr_data    = (state == ST_W_DATA) ? w_q    : S_AXI_WDATA;
    wr_strb    = (state == ST_W_DATA) ? strb_q : S_AXI_WSTRB;
    rd_capture = ar_hs;
    rd_addr    = S_AXI_ARADDR;
  end

  // Handshake state machine with registered response channels
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      aw_q         <= '0;
      w_q          <= '0;
      strb_q       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
    end else begin
      if (wr_commit) begin
        state       <= ST_W_RESP;
        S_AXI_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      case (state)
        ST_IDLE: begin
          if (!wr_commit) begin
            if (aw_hs) begin
              aw_q  <= S_AXI_AWADDR;
              state <= ST_W_ADDR;
            end else if (w_hs) begin
              w_q    <= S_AXI_WDATA;
              strb_q <= S_AXI_WSTRB;
              state  <= ST_W_DATA;
            end else if (ar_hs) begin
              S_AXI_RDATA  <= rd_data;
              S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
              S_AXI_RVALID <= 1'b1;
              state        <= ST_R_RESP;
            end
          end
        end
        // BVALID rises one cycle after the commit edge
        ST_W_RESP: begin
          if (!S_AXI_BVALID) S_AXI_BVALID <= 1'b1;
          else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_R_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axil_cfg_regfile.sv
// Control/status/config register file for the batch accelerator behind an
// AXI4-Lite slave; drives CTRL levels, a start pulse, config words and irq.
module axil_cfg_regfile
  import axil_cfg_regfile_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int NCFG     = 5,
  parameter int CFG_W    = 9,
  parameter bit ERR_RESP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  input  logic                  busy,
  input  logic                  done_evt,
  output logic                  matw,
  output logic                  run,
  output logic                  last,
  output logic                  start,
  output logic [NCFG*CFG_W-1:0] cfg,
  output logic                  irq
);

  logic                  wr_commit, wr_err, rd_capture, rd_err;
  logic [ADDR_W-1:0]     wr_addr, rd_addr;
  logic [31:0]           wr_data, rd_data, wmask;
  logic [3:0]            wr_strb;
  logic [2:0]            ctrl_lvl;
  logic                  irq_en, done, start_err;
  logic [NCFG-1:0][CFG_W-1:0] cfg_q;
  logic                  wr_ctrl, wr_stat;
  logic                  start_req, done_clr, serr_clr;
  int                    wr_w, wr_k, rd_w, rd_k;
  logic                  unused_ok;

  axil_lite_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk, .reset,
    .S_AXI_AWADDR, .S_AXI_AWVALID, .S_AXI_AWREADY,
    .S_AXI_WDATA, .S_AXI_WSTRB, .S_AXI_WVALID, .S_AXI_WREADY,
    .S_AXI_BRESP, .S_AXI_BVALID, .S_AXI_BREADY,
    .S_AXI_ARADDR, .S_AXI_ARVALID, .S_AXI_ARREADY,
    .S_AXI_RDATA, .S_AXI_RRESP, .S_AXI_RVALID, .S_AXI_RREADY,
    .wr_commit, .wr_addr, .wr_data, .wr_strb, .wr_err,
    .rd_capture, .rd_addr, .rd_data, .rd_err
  );

  assign unused_ok = ^{wr_data, wr_addr[1:0], rd_addr[1:0], rd_capture};
  assign {last, run, matw} = ctrl_lvl;
  assign cfg = cfg_q;

  // Write decode and side-effect qualifiers
  always_comb begin
    wr_w      = int'(wr_addr[ADDR_W-1:2]);
    wr_k      = wr_w - OFF_CFG_BASE;
    wr_ctrl   = (wr_w == OFF_CTRL);
    wr_stat   = (wr_w == OFF_STATUS);
    wr_err    = ERR_RESP & ~(wr_ctrl | wr_stat | (wr_k >= 0 && wr_k < NCFG));
    wmask     = strb_mask(wr_strb);
    start_req = wr_commit & wr_ctrl & wr_strb[1] & wr_data[CTRL_START];
    done_clr  = wr_commit & wr_stat & wr_strb[0] & wr_data[STAT_DONE];
    serr_clr  = wr_commit & wr_stat & wr_strb[0] & wr_data[STAT_SERR];
  end

  // Read mux; sampled by the FSM on the AR handshake edge
  always_comb begin
    rd_w    = int'(rd_addr[ADDR_W-1:2]);
    rd_k    = rd_w - OFF_CFG_BASE;
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_w == OFF_CTRL) begin
      rd_data[CTRL_LAST:CTRL_MATW] = ctrl_lvl;
      rd_data[CTRL_IRQEN]          = irq_en;
    end else if (rd_w == OFF_STATUS) begin
      rd_data[STAT_BUSY] = busy;
      rd_data[STAT_DONE] = done;
      rd_data[STAT_SERR] = start_err;
    end else if (rd_k >= 0 && rd_k < NCFG) begin
      for (int k = 0; k < NCFG; k++)
        if (rd_k == k) rd_data[CFG_W-1:0] = cfg_q[k];
    end else begin
      rd_err = ERR_RESP;
    end
  end

  // Register storage, sticky status (set beats W1C clear) and irq
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_lvl  <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      start     <= 1'b0;
      irq       <= 1'b0;
      cfg_q     <= '0;
    end else begin
      start     <= start_req & ~busy;
      done      <= (done & ~done_clr) | done_evt;
      start_err <= (start_err & ~serr_clr) | (start_req & busy);
      irq       <= done & irq_en;
      if (wr_commit && wr_ctrl) begin
        if (wr_strb[0]) ctrl_lvl <= wr_data[CTRL_LAST:CTRL_MATW];
        if (wr_strb[1]) irq_en   <= wr_data[CTRL_IRQEN];
      end
      for (int k = 0; k < NCFG; k++)
        if (wr_commit && wr_k == k)
          cfg_q[k] <= (cfg_q[k] & ~wmask[CFG_W-1:0]) | (wr_data[CFG_W-1:0] & wmask[CFG_W-1:0]);
    end
  end

endmodule

// File: tb/tb_axil_cfg_regfile.sv
// Directed bench for axil_cfg_regfile: a vector table of AXI accesses plus
// hand-written sequences for timing, start/irq, ordering and reset corners.
module tb_axil_cfg_regfile;

  localparam int ADDR_W = 12;
  localparam int NCFG   = 5;
  localparam int CFG_W  = 9;

  logic clk = 1'b0, reset = 1'b1;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic busy = 0, done_evt = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic matw, run, last, start, irq;
  logic [NCFG*CFG_W-1:0] cfg;

  int n_chk = 0, n_fail = 0, start_cnt = 0;

  axil_cfg_regfile #(.ADDR_W(ADDR_W), .NCFG(NCFG), .CFG_W(CFG_W), .ERR_RESP(1'b1)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .busy(busy), .done_evt(done_evt), .matw(matw), .run(run), .last(last),
    .start(start), .cfg(cfg), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start) start_cnt <= start_cnt + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [CFG_W-1:0] cfgk(input int k);
    return cfg[k*CFG_W +: CFG_W];
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic axi_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [1:0] resp);
    bit ok = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    cyc(); awvalid = 0; wvalid = 0;
    if (!ok) chk("wr_addr_timeout", 0, 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    if (!ok) chk("bvalid_timeout", 0, 1);
    resp = bresp; bready = 1; cyc(); bready = 0;
  endtask

  task automatic axi_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok = 0;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    cyc(); arvalid = 0;
    if (!ok) chk("arready_timeout", 0, 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    if (!ok) chk("rvalid_timeout", 0, 1);
    d = rdata; resp = rresp; rready = 1; cyc(); rready = 0;
  endtask

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
    logic [31:0]       exp;
    logic [1:0]        resp;
  } vec_t;

  vec_t vt[18];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int s0;
    bit ok;

    // rd, addr, wdata, strb, expected rdata, expected resp
    vt[0]  = '{0, 12'h00C, 32'h0000_00AA, 4'hF, 32'h0,     2'b00};
    vt[1]  = '{1, 12'h00C, 32'h0,         4'h0, 32'h0AA,   2'b00};
    vt[2]  = '{0, 12'h00C, 32'h0001_FFFF, 4'h1, 32'h0,     2'b00};
    vt[3]  = '{1, 12'h00C, 32'h0,         4'h0, 32'h0FF,   2'b00};
    vt[4]  = '{0, 12'h008, 32'h0000_00FF, 4'hF, 32'h0,     2'b00};
    vt[5]  = '{0, 12'h008, 32'h0000_FFFF, 4'h2, 32'h0,     2'b00};
    vt[6]  = '{1, 12'h008, 32'h0,         4'h0, 32'h1FF,   2'b00};
    vt[7]  = '{0, 12'h018, 32'hFFFF_F123, 4'hF, 32'h0,     2'b00};
    vt[8]  = '{1, 12'h018, 32'h0,         4'h0, 32'h123,   2'b00};
    vt[9]  = '{0, 12'h01C, 32'h0000_DEAD, 4'hF, 32'h0,     2'b10};
    vt[10] = '{1, 12'h01C, 32'h0,         4'h0, 32'h0,     2'b10};
    vt[11] = '{1, 12'h3FC, 32'h0,         4'h0, 32'h0,     2'b10};
    vt[12] = '{0, 12'h3FC, 32'hFFFF_FFFF, 4'hF, 32'h0,     2'b10};
    vt[13] = '{1, 12'h00E, 32'h0,         4'h0, 32'h0FF,   2'b00};
    vt[14] = '{0, 12'h000, 32'h0000_0205, 4'hF, 32'h0,     2'b00};
    vt[15] = '{1, 12'h000, 32'h0,         4'h0, 32'h205,   2'b00};
    vt[16] = '{1, 12'h004, 32'h0,         4'h0, 32'h0,     2'b00};
    vt[17] = '{0, 12'h000, 32'h0000_0000, 4'hF, 32'h0,     2'b00};

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    cyc(); reset = 0;
    @(negedge clk);
    chk("idle_readies", {awready, wready, arready}, 3'b111);
    chk("rst_valids", {bvalid, rvalid, start, irq}, 4'b0);
    chk("rst_cfg", cfg, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ctrl", {last, run, matw}, 0);
    cyc();

    // AW in cycle 0, W in cycle 3 -> BVALID in cycle 5
    awaddr = 12'h010; awvalid = 1;
    @(negedge clk); chk("t1_aw_acc", awready, 1);
    cyc(); awvalid = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("t1_waddr_rdy", {awready, wready, arready}, 3'b010);
      cyc();
    end
    wdata = 32'h1AB; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); chk("t1_w_acc", wready, 1);
    cyc(); wvalid = 0;
    @(negedge clk); chk("t1_bvalid_c4", bvalid, 0);
    cyc();
    @(negedge clk);
    chk("t1_bvalid_c5", bvalid, 1);
    chk("t1_bresp", bresp, 0);
    chk("t1_cfg2", cfgk(2), 9'h1AB);
    bready = 1; cyc(); bready = 0;

    // Vector table
    for (int i = 0; i < 18; i++) begin
      if (vt[i].rd) begin
        axi_rd(vt[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp);
        chk($sformatf("vec%0d_rresp", i), r, vt[i].resp);
      end else begin
        axi_wr(vt[i].addr, vt[i].data, vt[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), r, vt[i].resp);
      end
    end
    chk("cfg_vector", cfg, {9'h123, 9'h000, 9'h1AB, 9'h0FF, 9'h1FF});
    chk("ctrl_cleared", {last, run, matw}, 0);

    // START pulse, then START while busy -> start_err
    s0 = start_cnt;
    axi_wr(12'h000, 32'h102, 4'hF, r);
    cyc(); cyc();
    chk("t3_start_pulses", start_cnt - s0, 1);
    chk("t3_ctrl", {last, run, matw}, 3'b010);
    busy = 1; s0 = start_cnt;
    axi_wr(12'h000, 32'h102, 4'hF, r);
    cyc(); cyc();
    chk("t3_busy_nostart", start_cnt - s0, 0);
    axi_rd(12'h004, d, r);
    chk("t3_status", d, 32'h5);
    busy = 0;
    axi_wr(12'h004, 32'h4, 4'hF, r);
    axi_rd(12'h004, d, r);
    chk("t3_serr_clr", d, 32'h0);

    // done/irq, then W1C racing a new done_evt
    axi_wr(12'h000, 32'h200, 4'hF, r);
    done_evt = 1; cyc(); done_evt = 0;
    @(negedge clk); chk("t4_irq_lat0", irq, 0);
    cyc();
    @(negedge clk); chk("t4_irq", irq, 1);
    awaddr = 12'h004; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; done_evt = 1;
    cyc(); awvalid = 0; wvalid = 0; done_evt = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    chk("t4_bvalid_seen", ok, 1);
    bready = 1; cyc(); bready = 0;
    axi_rd(12'h004, d, r);
    chk("t4_done_set_wins", d, 32'h2);
    chk("t4_irq_held", irq, 1);
    axi_wr(12'h004, 32'h2, 4'h1, r);
    cyc(); cyc();
    @(negedge clk); chk("t4_irq_clr", irq, 0);
    cyc();

    // Simultaneous write and read: write first, BREADY stalled 4 cycles
    awaddr = 12'h014; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 12'h014; arvalid = 1;
    @(negedge clk); chk("t5_ar_blocked", {awready, arready}, 2'b10);
    cyc(); awvalid = 0; wvalid = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    chk("t5_bvalid_seen", ok, 1);
    for (int c = 0; c < 4; c++) begin
      cyc(); @(negedge clk);
      chk("t5_b_hold", {bvalid, bresp, arready}, 4'b1000);
    end
    bready = 1; cyc(); bready = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    chk("t5_ar_accept", ok, 1);
    cyc(); arvalid = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_r_hold", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'h55});
      cyc();
    end
    rready = 1; cyc(); rready = 0;
    @(negedge clk); chk("t5_rvalid_drop", rvalid, 0);
    cyc();

    // Reset in W_ADDR abandons the write
    awaddr = 12'h010; awvalid = 1;
    cyc(); awvalid = 0;
    @(negedge clk); chk("t6_in_waddr", {awready, wready}, 2'b01);
    cyc();
    reset = 1; wdata = 32'h0; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); chk("t6_wready_rst", wready, 0);
    cyc();
    @(negedge clk);
    chk("t6_rst_out", {awready, wready, arready, bvalid, rvalid, start, irq}, 7'b0);
    chk("t6_rst_data", {bresp, rresp, rdata}, 36'b0);
    chk("t6_rst_regs", {cfg, last, run, matw}, 48'b0);
    reset = 0; wvalid = 0;
    cyc();
    @(negedge clk);
    chk("t6_idle", {awready, wready, arready, bvalid}, 4'b1110);
    chk("t6_no_commit", cfgk(2), 9'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
